// File: rtl/dma_master_pkg.sv
// Shared types and helpers for the DMA read/write masters: FSM state type,
// default bus widths and the word-aligned length mask.
package dma_master_pkg;

  localparam int DEF_DATAWIDTH      = 32;
  localparam int DEF_ADDRESSWIDTH   = 32;
  localparam int DEF_FIFODEPTH      = 32;
  localparam int DEF_FIFODEPTH_LOG2 = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } wm_state_e;

  // Clears the byte-offset bits so a trailing partial word is dropped.
  function automatic logic [63:0] word_len_mask(input int unsigned bytes_per_word);
    return ~(64'(bytes_per_word) - 64'd1);
  endfunction

endpackage

// File: rtl/sync_showahead_fifo.sv
// Single-clock show-ahead FIFO: dout always presents the head word, which
// only changes on a pop. Pushes while full and pops while empty are ignored.
module sync_showahead_fifo
  import dma_master_pkg::*;
#(
  parameter int WIDTH      = DEF_DATAWIDTH,
  parameter int DEPTH      = DEF_FIFODEPTH,
  parameter int DEPTH_LOG2 = DEF_FIFODEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   used
);

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_used;
  logic                  w_push;
  logic                  w_pop;

  assign empty  = (r_used == '0);
  assign full   = (r_used == (DEPTH_LOG2+1)'(DEPTH));
  assign used   = r_used;
  assign dout   = r_mem[r_rd_ptr];
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_used   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_used <= r_used + 1'b1;
        2'b01:   r_used <= r_used - 1'b1;
        default: r_used <= r_used;
      endcase
    end
  end

  // Storage needs no reset; a flushed FIFO never exposes stale entries as valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/buffered_write_master.sv
// Avalon-MM write master draining a show-ahead FIFO as word writes from a
// programmed base/length. Define BUFFERED_WRITE_MASTER_WORD_COUNT_EN to add words_written.
module buffered_write_master
  import dma_master_pkg::*;
#(
  parameter int DATAWIDTH       = DEF_DATAWIDTH,
  parameter int BYTEENABLEWIDTH = DEF_DATAWIDTH / 8,
  parameter int ADDRESSWIDTH    = DEF_ADDRESSWIDTH,
  parameter int FIFODEPTH       = DEF_FIFODEPTH,
  parameter int FIFODEPTH_LOG2  = DEF_FIFODEPTH_LOG2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       control_fixed_location,
  input  logic [ADDRESSWIDTH-1:0]    control_write_base,
  input  logic [ADDRESSWIDTH-1:0]    control_write_length,
  input  logic                       control_go,
  output logic                       control_done,
  input  logic                       user_write_buffer,
  input  logic [DATAWIDTH-1:0]       user_buffer_data,
  output logic                       user_buffer_full,
  output logic [ADDRESSWIDTH-1:0]    master_address,
  output logic                       master_write,
  output logic [BYTEENABLEWIDTH-1:0] master_byteenable,
  output logic [DATAWIDTH-1:0]       master_writedata,
  input  logic                       master_waitrequest
`ifdef BUFFERED_WRITE_MASTER_WORD_COUNT_EN
  ,
  output logic [ADDRESSWIDTH-1:0]    words_written
`endif
);

  localparam logic [ADDRESSWIDTH-1:0] BE_BYTES = ADDRESSWIDTH'(BYTEENABLEWIDTH);
  localparam logic [ADDRESSWIDTH-1:0] LEN_MASK = ADDRESSWIDTH'(word_len_mask(BYTEENABLEWIDTH));

  wm_state_e             r_state;
  logic [ADDRESSWIDTH-1:0] r_address;
  logic [ADDRESSWIDTH-1:0] r_length;
  logic                  r_fixed_d1;

  logic [ADDRESSWIDTH-1:0] w_go_len;
  logic                  w_empty;
  logic                  w_full;
  logic [FIFODEPTH_LOG2:0] w_used;
  logic                  w_unused_used;
  logic                  w_push;
  logic                  w_accept;

  assign w_go_len          = control_write_length & LEN_MASK;
  assign w_push            = user_write_buffer & ~w_full;
  assign w_accept          = master_write & ~master_waitrequest;
  assign w_unused_used     = ^w_used;

  assign control_done      = (r_state != WRITE);
  assign master_write      = (r_state == WRITE) & ~w_empty;
  assign master_address    = r_address;
  assign master_byteenable = '1;
  assign user_buffer_full  = w_full;

  sync_showahead_fifo #(
    .WIDTH      (DATAWIDTH),
    .DEPTH      (FIFODEPTH),
    .DEPTH_LOG2 (FIFODEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_accept),
    .din   (user_buffer_data),
    .dout  (master_writedata),
    .empty (w_empty),
    .full  (w_full),
    .used  (w_used)
  );

  // A go wins over a same-cycle accept; the accepted word is still popped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_address  <= '0;
      r_length   <= '0;
      r_fixed_d1 <= 1'b0;
    end else if (control_go) begin
      r_address  <= control_write_base;
      r_length   <= w_go_len;
      r_fixed_d1 <= control_fixed_location;
      r_state    <= (w_go_len != '0) ? WRITE : DONE;
    end else if (w_accept) begin
      r_length <= r_length - BE_BYTES;
      if (!r_fixed_d1) r_address <= r_address + BE_BYTES;
      if (r_length == BE_BYTES) r_state <= DONE;
    end
  end

`ifdef BUFFERED_WRITE_MASTER_WORD_COUNT_EN
  logic [ADDRESSWIDTH-1:0] r_words_written;
  assign words_written = r_words_written;

  always_ff @(posedge clk) begin
    if (reset || control_go) r_words_written <= '0;
    else if (w_accept)       r_words_written <= r_words_written + 1'b1;
  end
`endif

endmodule

// File: tb/tb_buffered_write_master.sv
// Directed-sequence bench with random data/addresses for buffered_write_master;
// expected writes come from a queue of pushed words and base/length arithmetic.
module tb_buffered_write_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        control_fixed_location;
  logic [31:0] control_write_base;
  logic [31:0] control_write_length;
  logic        control_go;
  logic        control_done;
  logic        user_write_buffer;
  logic [31:0] user_buffer_data;
  logic        user_buffer_full;
  logic [31:0] master_address;
  logic        master_write;
  logic [3:0]  master_byteenable;
  logic [31:0] master_writedata;
  logic        master_waitrequest;
`ifdef BUFFERED_WRITE_MASTER_WORD_COUNT_EN
  logic [31:0] words_written;
`endif

  int checks   = 0;
  int failures = 0;

  logic [63:0] got[$];       // {address, data} of every accepted write
  logic [31:0] exp_data[$];  // words the model believes are in the FIFO

  always #5 clk = ~clk;

  buffered_write_master dut (
    .clk                    (clk),
    .reset                  (reset),
    .control_fixed_location (control_fixed_location),
    .control_write_base     (control_write_base),
    .control_write_length   (control_write_length),
    .control_go             (control_go),
    .control_done           (control_done),
    .user_write_buffer      (user_write_buffer),
    .user_buffer_data       (user_buffer_data),
    .user_buffer_full       (user_buffer_full),
    .master_address         (master_address),
    .master_write           (master_write),
    .master_byteenable      (master_byteenable),
    .master_writedata       (master_writedata),
    .master_waitrequest     (master_waitrequest)
`ifdef BUFFERED_WRITE_MASTER_WORD_COUNT_EN
    ,
    .words_written          (words_written)
`endif
  );

  always @(posedge clk) begin
    if (!reset && master_write && !master_waitrequest)
      got.push_back({master_address, master_writedata});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      user_write_buffer = 1'b1;
      user_buffer_data  = $urandom;
      if (exp_data.size() < 32) exp_data.push_back(user_buffer_data);
      tick();
    end
    user_write_buffer = 1'b0;
  endtask

  task automatic go(input logic [31:0] base, input logic [31:0] len, input logic fixed);
    control_go             = 1'b1;
    control_write_base     = base;
    control_write_length   = len;
    control_fixed_location = fixed;
    tick();
    control_go = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!control_done && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, 64'(n < budget), 64'd1);
  endtask

  task automatic check_writes(input string tag, input int n, input logic [31:0] base,
                              input logic fixed);
    logic [63:0] w;
    logic [31:0] ed;
    chk({tag, "_count"}, 64'(got.size()), 64'(n));
    for (int i = 0; i < n && got.size() > 0; i++) begin
      w  = got.pop_front();
      ed = (exp_data.size() > 0) ? exp_data.pop_front() : 32'h0;
      chk({tag, "_addr"}, 64'(w[63:32]), 64'(fixed ? base : base + 32'(4 * i)));
      chk({tag, "_data"}, 64'(w[31:0]), 64'(ed));
    end
    got.delete();
  endtask

  initial begin
    logic [31:0] base;
    int n;
    reset = 1'b1;
    control_fixed_location = 1'b0;
    control_write_base = '0;
    control_write_length = '0;
    control_go = 1'b0;
    user_write_buffer = 1'b0;
    user_buffer_data = '0;
    master_waitrequest = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_done", 64'(control_done), 64'd1);
    chk("rst_write", 64'(master_write), 64'd0);
    chk("rst_full", 64'(user_buffer_full), 64'd0);
    chk("rst_addr", 64'(master_address), 64'd0);
    chk("byteenable", 64'(master_byteenable), 64'hF);

    // Basic transfer: words pushed after go stream straight out.
    go(32'h1000, 32'd16, 1'b0);
    push_words(4);
    n = 0;
    while (got.size() < 4 && n < 50) begin
      chk("t1_done_low", 64'(control_done), 64'd0);
      tick();
      n++;
    end
    chk("t1_done_high", 64'(control_done), 64'd1);
    chk("t1_write_low", 64'(master_write), 64'd0);
    check_writes("t1", 4, 32'h1000, 1'b0);
`ifdef BUFFERED_WRITE_MASTER_WORD_COUNT_EN
    chk("wc_after_t1", 64'(words_written), 64'd4);
`endif

    // Stall on the second write: address and data must hold.
    push_words(4);
    go(32'h2000, 32'd16, 1'b0);
`ifdef BUFFERED_WRITE_MASTER_WORD_COUNT_EN
    chk("wc_cleared", 64'(words_written), 64'd0);
`endif
    chk("t2_first_addr", 64'(master_address), 64'h2000);
    chk("t2_first_data", 64'(master_writedata), 64'(exp_data[0]));
    tick();
    master_waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_hold_write", 64'(master_write), 64'd1);
      chk("t2_hold_addr", 64'(master_address), 64'h2004);
      chk("t2_hold_data", 64'(master_writedata), 64'(exp_data[1]));
      if (i < 3) tick();
    end
    master_waitrequest = 1'b0;
    wait_done("t2", 50);
    check_writes("t2", 4, 32'h2000, 1'b0);

    // Fill to full with no transfer running; the 33rd word is dropped.
    for (int i = 0; i < 33; i++) begin
      push_words(1);
      if (i == 31) chk("t3_full", 64'(user_buffer_full), 64'd1);
    end
    chk("t3_still_full", 64'(user_buffer_full), 64'd1);
    chk("t3_model_depth", 64'(exp_data.size()), 64'd32);
    base = $urandom & 32'hFFFF_FFFC;
    go(base, 32'd128, 1'b0);
    wait_done("t3", 200);
    check_writes("t3", 32, base, 1'b0);
    chk("t3_not_full", 64'(user_buffer_full), 64'd0);

    // Fixed location, partial trailing word, zero length.
    push_words(3);
    base = $urandom & 32'hFFFF_FFFC;
    go(base, 32'd12, 1'b1);
    wait_done("t4a", 50);
    check_writes("t4a", 3, base, 1'b1);
    push_words(2);
    base = $urandom & 32'hFFFF_FFFC;
    go(base, 32'd6, 1'b0);
    wait_done("t4b", 50);
    check_writes("t4b", 1, base, 1'b0);
    go(32'h5000, 32'd3, 1'b0);
    chk("t4c_done", 64'(control_done), 64'd1);
    chk("t4c_write", 64'(master_write), 64'd0);
    tick();
    tick();
    chk("t4c_no_writes", 64'(got.size()), 64'd0);

    // Reset mid-transfer: leftover word plus 4 new ones, abort after 2 writes.
    push_words(4);
    go(32'h4000, 32'd16, 1'b0);
    n = 0;
    while (got.size() < 2 && n < 50) begin
      tick();
      n++;
    end
    check_writes("t5_pre", 2, 32'h4000, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_data.delete();
    got.delete();
    chk("t5_write", 64'(master_write), 64'd0);
    chk("t5_done", 64'(control_done), 64'd1);
    chk("t5_full", 64'(user_buffer_full), 64'd0);
    chk("t5_addr", 64'(master_address), 64'd0);
    go(32'h6000, 32'd8, 1'b0);
    tick();
    tick();
    chk("t5_flushed", 64'(got.size()), 64'd0);
    chk("t5_waiting", 64'(control_done), 64'd0);
    push_words(2);
    wait_done("t5_post", 50);
    check_writes("t5_post", 2, 32'h6000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
